// File: rtl/ca_rng_pkg.sv
// ca_rng_pkg: shared types and constants for the CA word buffer
package ca_rng_pkg;
  typedef enum logic {WARM, RUN} state_e;
  localparam int DROP_W = 8;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ca_fifo.sv
// ca_fifo: wrap-bit pointer FIFO with registered head word and push-on-full-with-pop
module ca_fifo import ca_rng_pkg::*; #(
  parameter int N = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_ready,
  input  logic [N-1:0] i_data,
  output logic         o_valid,
  output logic [N-1:0] o_data,
  output logic         o_full
);
  localparam int PW = ptr_w(DEPTH);
  logic [N-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic          r_valid;
  logic [N-1:0]  r_head;
  logic          w_pop, w_push_ok, w_valid_nxt;
  logic [PW-1:0] w_wr_nxt, w_rd_nxt;
  logic [PW-2:0] w_wr_i, w_rd_nxt_i;
  logic [N-1:0]  w_head_nxt;
  assign w_wr_i      = r_wr[PW-2:0];
  assign o_full      = r_wr == {~r_rd[PW-1], r_rd[PW-2:0]};
  assign w_pop       = r_valid & i_ready & ~i_clr;
  assign w_push_ok   = i_push & ~i_clr & (~o_full | w_pop);
  assign w_wr_nxt    = r_wr + PW'(w_push_ok);
  assign w_rd_nxt    = r_rd + PW'(w_pop);
  assign w_rd_nxt_i  = w_rd_nxt[PW-2:0];
  assign w_valid_nxt = w_wr_nxt != w_rd_nxt;
  // the head after this edge is the incoming word when it lands in the next read slot
  assign w_head_nxt  = (w_push_ok && w_wr_i == w_rd_nxt_i) ? i_data : r_mem[w_rd_nxt_i];
  assign o_valid     = r_valid;
  assign o_data      = r_head;
  // storage write
  always_ff @(posedge clk)
    if (w_push_ok) r_mem[w_wr_i] <= i_data;
  // pointers, valid flag and registered head word
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else if (i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_valid <= w_valid_nxt;
      r_head  <= w_valid_nxt ? w_head_nxt : r_head;
    end
endmodule

// File: rtl/ca_word_buffer.sv
// ca_word_buffer: warm-up discard, FIFO buffering and drop counting of CA words
module ca_word_buffer import ca_rng_pkg::*; #(
  parameter int N = 32,
  parameter int DEPTH = 4,
  parameter int WARMUP = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              flush,
  input  logic [N-1:0]      ca_word_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic              warm_done,
  output logic [DROP_W-1:0] drop_count
);
  localparam int WCW = (WARMUP > 2) ? $clog2(WARMUP) : 1;
  state_e            r_state, w_state_nxt;
  logic [WCW-1:0]    r_warm_cnt, w_cnt_nxt;
  logic [DROP_W-1:0] r_drop;
  logic              w_open, w_push, w_full, w_drop;
  // with no warm-up the very first enable after reset/flush is already a push
  assign w_open     = (r_state == RUN) || (WARMUP == 0);
  assign w_push     = enable & ~flush & w_open;
  assign w_drop     = w_push & w_full & ~(out_valid & out_ready);
  assign warm_done  = r_state == RUN;
  assign drop_count = r_drop;
  ca_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .i_clr(flush), .i_push(w_push),
    .i_ready(out_ready), .i_data(ca_word_in),
    .o_valid(out_valid), .o_data(out_data), .o_full(w_full)
  );
  // warm-up state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state    <= WARM;
      r_warm_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_warm_cnt <= w_cnt_nxt;
    end
  // warm-up next state: count enabled discards, flush restarts the run
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_warm_cnt;
    if (flush) begin
      w_state_nxt = WARM;
      w_cnt_nxt   = '0;
    end else if (r_state == WARM && (WARMUP == 0 || enable)) begin
      if (WARMUP == 0 || r_warm_cnt == WCW'(WARMUP - 1)) w_state_nxt = RUN;
      else w_cnt_nxt = r_warm_cnt + 1'b1;
    end
  end
  // saturating count of pushes lost to a full FIFO
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_drop <= '0;
    else if (w_drop && r_drop != '1) r_drop <= r_drop + 1'b1;
endmodule

// File: tb/tb_ca_word_buffer.sv
// tb_ca_word_buffer: random and directed checks of ca_word_buffer against a queue model
module tb_ca_word_buffer;
  localparam int D = 4;
  localparam int WU [2] = '{4, 0};
  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] ca_word_in = '0;
  logic ov [2];
  logic [31:0] od [2];
  logic wd [2];
  logic [7:0] dc [2];
  logic [31:0] mq [2][D];
  int mn [2], cnt [2], drp [2];
  bit run [2];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ca_word_buffer #(.N(32), .DEPTH(4), .WARMUP(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush), .ca_word_in(ca_word_in),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .warm_done(wd[0]), .drop_count(dc[0]));
  ca_word_buffer #(.N(32), .DEPTH(4), .WARMUP(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush), .ca_word_in(ca_word_in),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .warm_done(wd[1]), .drop_count(dc[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mn[i] = 0; cnt[i] = 0; drp[i] = 0; run[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit pop, req;
    if (flush) begin
      mn[i] = 0; run[i] = 0; cnt[i] = 0;
      return;
    end
    pop = mn[i] > 0 && out_ready;
    req = enable && (run[i] || WU[i] == 0);
    if (pop) begin
      for (int k = 0; k < D - 1; k++) mq[i][k] = mq[i][k+1];
      mn[i]--;
    end
    if (!run[i]) begin
      if (WU[i] == 0) run[i] = 1;
      else if (enable) begin
        if (cnt[i] == WU[i] - 1) run[i] = 1;
        else cnt[i]++;
      end
    end
    if (req) begin
      if (mn[i] < D) begin
        mq[i][mn[i]] = ca_word_in;
        mn[i]++;
      end else if (drp[i] < 255) drp[i]++;
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid%0d", i), 32'(ov[i]), 32'(mn[i] > 0));
      chk($sformatf("warm_done%0d", i), 32'(wd[i]), 32'(run[i]));
      chk($sformatf("drop%0d", i), 32'(dc[i]), 32'(drp[i]));
      if (mn[i] > 0) chk($sformatf("data%0d", i), od[i], mq[i][0]);
    end
  endtask

  task automatic step(input logic en, input logic fl, input logic rdy, input logic [31:0] d);
    enable = en; flush = fl; out_ready = rdy; ca_word_in = d;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic chk_reset_outputs();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst_data%0d", i), od[i], 32'd0);
      chk($sformatf("rst_warm%0d", i), 32'(wd[i]), 32'd0);
      chk($sformatf("rst_drop%0d", i), 32'(dc[i]), 32'd0);
    end
  endtask

  initial begin
    model_reset();
    #2;
    chk_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;
    for (int w = 1; w <= 6; w++) begin
      step(1'b1, 1'b0, 1'b1, 32'(w));
      if (w == 3) chk("warm_pending", 32'(wd[0]), 32'd0);
      if (w == 4) begin
        chk("warm_rise", 32'(wd[0]), 32'd1);
        chk("warm_no_out", 32'(ov[0]), 32'd0);
      end
      if (w >= 5) chk("warm_word", od[0], 32'(w));
    end
    step(1'b0, 1'b0, 1'b1, 32'd0);
    chk("drained", 32'(ov[0]), 32'd0);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 32'hA0 + 32'(k));
    chk("fill_drop", 32'(dc[0]), 32'd2);
    chk("fill_head", od[0], 32'hA0);
    for (int k = 1; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, 32'd0);
      chk("fill_read", od[0], 32'hA0 + 32'(k));
    end
    step(1'b0, 1'b0, 1'b1, 32'd0);
    chk("fill_empty", 32'(ov[0]), 32'd0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 32'hB0 + 32'(k));
    step(1'b1, 1'b0, 1'b1, 32'hC0);
    chk("fullpop_nodrop", 32'(dc[0]), 32'd2);
    chk("fullpop_head", od[0], 32'hB1);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    chk("fullpop_last", od[0], 32'hC0);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'hD0);
    step(1'b1, 1'b0, 1'b0, 32'hD1);
    step(1'b1, 1'b1, 1'b0, 32'hEE);
    chk("flush_valid", 32'(ov[0]), 32'd0);
    chk("flush_warm", 32'(wd[0]), 32'd0);
    chk("flush_drop", 32'(dc[0]), 32'd2);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 1'b0, 1'b1, 32'hE0 + 32'(k));
      if (k == 4) chk("flush_discard", 32'(ov[0]), 32'd0);
    end
    chk("flush_fifth", od[0], 32'hE5);
    for (int c = 0; c < 400; c++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)), $urandom);
    for (int c = 0; c < 300; c++) step(1'b1, 1'b0, 1'b0, $urandom);
    chk("sat_drop", 32'(dc[0]), 32'd255);
    step(1'b1, 1'b0, 1'b0, 32'h55);
    chk("sat_hold", 32'(dc[0]), 32'd255);
    #3;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, 32'h77);
    chk("w0_first_valid", 32'(ov[1]), 32'd1);
    chk("w0_first_data", od[1], 32'h77);
    for (int c = 0; c < 40; c++) step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ca_word_buffer.md
# ca_word_buffer

Downstream consumer of the cellular-automaton PRNG stage: samples the CA state word every enabled cycle, discards a programmable warm-up run after reset or flush, and buffers accepted words in a small FIFO. The FIFO is presented to the system on a valid/ready interface. A saturating drop counter records words lost to back-pressure. The block is the only path from the CA generator to PRNG consumers.

## Interface
- N, 32: word width; must match the CA stage width.
- DEPTH, 4: FIFO entries; power of two, 2..16.
- WARMUP, 16: enabled cycles discarded after reset/flush; 0 means no discard.
- clk  in  1  rising-edge clock, same domain as the CA stage.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  sample ca_word_in this cycle.
- flush  in  1  synchronous clear of the FIFO and restart of warm-up; pulsed when the CA stage is reseeded.
- ca_word_in  in  N  CA state word (CA data_out).
- out_valid  out  1  out_data holds an unread word.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  N  head-of-FIFO word.
- warm_done  out  1  high once warm-up is complete.
- drop_count  out  8  words dropped because the FIFO was full; saturates at 255.

## Operation
- Reset (async, reset_n low): state WARM, warm counter 0, FIFO empty, out_valid 0, out_data 0, warm_done 0, drop_count 0.
- State WARM: each enable cycle increments the warm counter and discards the word. On the enable cycle where the count reaches WARMUP-1, move to RUN; that word is also discarded. WARMUP=0 enters RUN directly from reset/flush, and the first enable cycle is a push.
- State RUN: warm_done is 1. An enable cycle is a push request.
  - FIFO not full: the word is written.
  - FIFO full, no pop this cycle: the word is dropped and drop_count increments, saturating at 255.
  - FIFO full with a pop this cycle: the push is accepted and occupancy stays at DEPTH.
- Pop: occurs when out_valid and out_ready are both high. The read pointer advances. out_ready with out_valid low has no effect.
- Simultaneous push and pop on a non-empty FIFO leaves occupancy unchanged. Push and pop on an empty FIFO is a push only, because no pop is possible.
- flush has priority over enable and pop.
  - Next cycle: FIFO empty, out_valid 0, state WARM, warm counter 0, warm_done 0.
  - drop_count is not cleared; only reset clears it.
  - The word presented during the flush cycle is discarded and not counted as warm-up.
- Pointers are log2(DEPTH)+1 bits, so full and empty are distinguished by the extra wrap bit. Pointers wrap modulo 2*DEPTH.
- out_data is valid only while out_valid is high. Its value when out_valid is low is don't-care, except after reset, when it is 0.

## Timing
- Push-to-visible latency is 1 cycle: a word pushed at edge k gives out_valid=1 with out_data equal to that word after edge k.
- Throughput is 1 word/cycle with out_ready held high; the FIFO then never fills.
- Pop at edge k: out_data shows the next entry (or out_valid drops) after edge k.
- out_valid, out_data, warm_done and drop_count are all registered outputs; there is no combinational path from inputs to outputs.
- warm_done rises at the edge that performs the final discard.
- drop_count updates at the edge of the dropped push.
- Deasserting reset_n mid-operation asynchronously forces all reset values. Operation resumes on the first rising edge after release.

## Structure
- Package ca_rng_pkg:
  - state enum {WARM, RUN}.
  - DROP_W=8 constant.
  - A clog2-based pointer-width localparam helper.
- One sub-module, ca_fifo: synchronous storage with registered head output, wrap-bit pointers, full/empty flags, and a push-when-full-with-pop rule.
- The top level holds the warm-up FSM, the flush logic and the drop counter.

## Test plan
All tests use N=32, DEPTH=4, WARMUP=4 unless noted.
- Warm-up: reset, enable high, ca_word_in = 1,2,3,4,5,6.
  - Words 1–4 are discarded; warm_done rises with word 4.
  - out_data=5 with out_valid=1 one cycle after word 5, then 6.
- Fill/drop: after warm-up, out_ready=0, push 0xA0..0xA5.
  - FIFO holds A0..A3; drop_count=2.
  - Raising out_ready yields A0, A1, A2, A3 on consecutive cycles, then out_valid=0.
- Full with simultaneous pop: FIFO full (B0..B3), push C0 with out_ready=1.
  - No drop; the pops yield B0..B3 and then C0.
- Flush mid-stream: FIFO holding 2 words, flush with enable high.
  - Next cycle out_valid=0 and warm_done=0.
  - 4 further words are discarded and the 5th appears at the output.
  - drop_count is unchanged.
- Saturation: out_ready=0, FIFO full, 300 enabled cycles.
  - drop_count=255 and holds.
- Async reset mid-run: assert reset_n low between edges with FIFO non-empty.
  - out_valid=0, out_data=0, drop_count=0 and warm_done=0 immediately, without waiting for a clock edge.
  - With WARMUP=0, the first enabled word after release appears one cycle later.
